// File: rtl/bit_ascii_printer.sv
// bit_ascii_printer: prints each queued byte as eight ASCII '0'/'1' characters,
// optionally followed by CR LF, through the UART transmitter handshake.
// A small input FIFO absorbs bursts of bytes while the serial side drains.
module bit_ascii_printer #(
    parameter int FIFO_DEPTH   = 4,
    parameter bit LSB_FIRST    = 1'b1,
    parameter bit SEND_NEWLINE = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    byte_in,
    input  logic                          new_byte,
    output logic                          ready,
    output logic [7:0]                    tx_data,
    output logic                          new_tx_data,
    input  logic                          tx_busy,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_SEND_BIT = 2'd1;
    localparam logic [1:0] S_SEND_CR  = 2'd2;
    localparam logic [1:0] S_SEND_LF  = 2'd3;

    // FIFO storage and pointers; pointers wrap naturally at the power-of-two depth
    logic [7:0]    r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;

    // printer state
    logic [1:0]    r_state;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bit_cnt;
    logic [7:0]    r_tx_data;
    logic          r_new_tx;

    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_send;
    logic          w_bit;
    logic          w_last_bit;

    // ready comes from the registered count only, so a pop in the same cycle
    // never makes room for a push that arrives while full
    assign w_ready    = (r_count != FULL_CNT);
    assign w_push     = new_byte && w_ready;
    assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
    // the transmitter raises tx_busy one cycle late, so a character is never
    // sent in the cycle right after a previous strobe
    assign w_send     = !tx_busy && !r_new_tx;
    assign w_bit      = LSB_FIRST ? r_shreg[0] : r_shreg[7];
    assign w_last_bit = (r_bit_cnt == 3'd7);

    assign ready       = w_ready;
    assign tx_data     = r_tx_data;
    assign new_tx_data = r_new_tx;
    assign overflow    = r_overflow;
    assign fifo_count  = r_count;
    assign busy        = (r_state != S_IDLE) || (r_count != '0);

    // FIFO storage write; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= byte_in;
        end
    end

    // shift register: loaded on pop, shifted once per printed bit
    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_shreg <= r_mem[r_rptr];
        end else if ((r_state == S_SEND_BIT) && w_send) begin
            r_shreg <= LSB_FIRST ? {1'b0, r_shreg[7:1]} : {r_shreg[6:0], 1'b0};
        end
    end

    // FIFO bookkeeping, sticky overflow flag and the printing FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_state    <= S_IDLE;
            r_bit_cnt  <= 3'd0;
            r_tx_data  <= 8'h00;
            r_new_tx   <= 1'b0;
        end else begin
            r_new_tx <= 1'b0;

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            if (new_byte && !w_ready) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_bit_cnt <= 3'd0;
                        r_state   <= S_SEND_BIT;
                    end
                end
                S_SEND_BIT: begin
                    if (w_send) begin
                        r_tx_data <= {7'b0011000, w_bit};
                        r_new_tx  <= 1'b1;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (w_last_bit) begin
                            r_state <= SEND_NEWLINE ? S_SEND_CR : S_IDLE;
                        end
                    end
                end
                S_SEND_CR: begin
                    if (w_send) begin
                        r_tx_data <= 8'h0D;
                        r_new_tx  <= 1'b1;
                        r_state   <= S_SEND_LF;
                    end
                end
                S_SEND_LF: begin
                    if (w_send) begin
                        r_tx_data <= 8'h0A;
                        r_new_tx  <= 1'b1;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_ascii_printer.sv
// Testbench for bit_ascii_printer: two instances (LSB-first with CR LF, and
// MSB-first without terminator) share all inputs; each output stream is
// scored against an expected-character queue.
module tb_bit_ascii_printer;

    localparam int DEPTH = 4;
    localparam logic [15:0] CRLF = 16'h0D0A;

    logic       clk = 1'b0;
    logic       rst;
    logic       new_byte;
    logic       tx_busy;
    logic [7:0] byte_in;

    logic       ready_a, new_tx_a, busy_a, ovf_a;
    logic [7:0] tx_a;
    logic [2:0] cnt_a;
    logic       ready_b, new_tx_b, busy_b, ovf_b;
    logic [7:0] tx_b;
    logic [2:0] cnt_b;

    always #5 clk = ~clk;

    bit_ascii_printer #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b1), .SEND_NEWLINE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .byte_in(byte_in), .new_byte(new_byte),
        .ready(ready_a), .tx_data(tx_a), .new_tx_data(new_tx_a), .tx_busy(tx_busy),
        .busy(busy_a), .overflow(ovf_a), .fifo_count(cnt_a)
    );

    bit_ascii_printer #(.FIFO_DEPTH(DEPTH), .LSB_FIRST(1'b0), .SEND_NEWLINE(1'b0)) dut_b (
        .clk(clk), .rst(rst), .byte_in(byte_in), .new_byte(new_byte),
        .ready(ready_b), .tx_data(tx_b), .new_tx_data(new_tx_b), .tx_busy(tx_busy),
        .busy(busy_b), .overflow(ovf_b), .fifo_count(cnt_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int na = 0;
    int nb = 0;
    int pa_cyc[$];
    logic [7:0] qa[$];
    logic [7:0] qb[$];

    logic       prev_busy = 1'b0;
    logic       prev_rst = 1'b1;
    logic       prev_nt_a = 1'b0;
    logic       prev_nt_b = 1'b0;
    logic [7:0] prev_tx_a = 8'h00;
    logic [7:0] prev_tx_b = 8'h00;

    typedef struct {
        logic [7:0]  din;
        logic [79:0] exp_a;
        logic [63:0] exp_b;
    } vec_t;
    vec_t vec [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        byte_in  = b;
        new_byte = 1'b1;
        tick();
        new_byte = 1'b0;
    endtask

    // reference: a byte becomes its bits as '0'/'1' text in reading order
    task automatic model_push(input logic [7:0] b);
        for (int i = 0; i < 8; i++) begin
            qa.push_back(8'h30 + {7'd0, b[i]});
            qb.push_back(8'h30 + {7'd0, b[7-i]});
        end
        qa.push_back(8'h0D);
        qa.push_back(8'h0A);
    endtask

    task automatic enq_str(input logic [79:0] sa, input logic [63:0] sb);
        for (int i = 0; i < 10; i++) qa.push_back(sa[79-8*i -: 8]);
        for (int i = 0; i < 8; i++)  qb.push_back(sb[63-8*i -: 8]);
    endtask

    task automatic wait_idle(input string name, input int maxc);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && n < maxc) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(n < maxc), 32'd1);
        repeat (4) tick();
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        prev_busy <= tx_busy;
        prev_rst  <= rst;
    end

    // stream scoreboard, LSB-first instance
    always @(negedge clk) begin
        if (new_tx_a === 1'b1) begin
            na <= na + 1;
            pa_cyc.push_back(cyc);
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_extra_char actual=%02h required=no_char", tx_a);
            end else begin
                check("a_char", {24'd0, tx_a}, {24'd0, qa.pop_front()});
            end
            check("a_gap", {31'd0, prev_nt_a}, 32'd0);
            check("a_busy_gate", {31'd0, prev_busy}, 32'd0);
        end else if (!prev_rst) begin
            check("a_hold", {24'd0, tx_a}, {24'd0, prev_tx_a});
        end
        prev_nt_a <= new_tx_a;
        prev_tx_a <= tx_a;
    end

    // stream scoreboard, MSB-first instance
    always @(negedge clk) begin
        if (new_tx_b === 1'b1) begin
            nb <= nb + 1;
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_extra_char actual=%02h required=no_char", tx_b);
            end else begin
                check("b_char", {24'd0, tx_b}, {24'd0, qb.pop_front()});
            end
            check("b_gap", {31'd0, prev_nt_b}, 32'd0);
            check("b_busy_gate", {31'd0, prev_busy}, 32'd0);
        end else if (!prev_rst) begin
            check("b_hold", {24'd0, tx_b}, {24'd0, prev_tx_b});
        end
        prev_nt_b <= new_tx_b;
        prev_tx_b <= tx_b;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, nb0, n1, nb1, c0, k, r;
        logic [7:0] hold_tx;
        logic [7:0] rb;

        vec[0] = '{8'h01, {"10000000", CRLF}, "00000001"};
        vec[1] = '{8'hC3, {"11000011", CRLF}, "11000011"};
        vec[2] = '{8'h0F, {"11110000", CRLF}, "00001111"};
        vec[3] = '{8'h80, {"00000001", CRLF}, "10000000"};
        vec[4] = '{8'h36, {"01101100", CRLF}, "00110110"};
        vec[5] = '{8'h00, {"00000000", CRLF}, "00000000"};

        rst = 1'b1; new_byte = 1'b0; tx_busy = 1'b0; byte_in = 8'h00;
        tick();
        tick();
        check("rst_tx_a", {24'd0, tx_a}, 32'h00);
        check("rst_new_a", {31'd0, new_tx_a}, 32'd0);
        check("rst_ready_a", {31'd0, ready_a}, 32'd1);
        check("rst_busy_a", {31'd0, busy_a}, 32'd0);
        check("rst_ovf_a", {31'd0, ovf_a}, 32'd0);
        check("rst_cnt_a", {29'd0, cnt_a}, 32'd0);
        check("rst_tx_b", {24'd0, tx_b}, 32'h00);
        check("rst_new_b", {31'd0, new_tx_b}, 32'd0);
        check("rst_ready_b", {31'd0, ready_b}, 32'd1);
        check("rst_busy_b", {31'd0, busy_b}, 32'd0);
        check("rst_ovf_b", {31'd0, ovf_b}, 32'd0);
        check("rst_cnt_b", {29'd0, cnt_b}, 32'd0);
        rst = 1'b0;
        tick();

        // table-driven single bytes: content, count, latency and spacing
        for (int i = 0; i < 6; i++) begin
            enq_str(vec[i].exp_a, vec[i].exp_b);
            pa_cyc.delete();
            n0 = na;
            nb0 = nb;
            push(vec[i].din);
            c0 = cyc;
            wait_idle("vec", 200);
            check("vec_count_a", 32'(na - n0), 32'd10);
            check("vec_count_b", 32'(nb - nb0), 32'd8);
            check("vec_pulses_a", 32'(pa_cyc.size()), 32'd10);
            if (pa_cyc.size() == 10) begin
                check("vec_latency_a", 32'(pa_cyc[0] - c0), 32'd2);
                for (int j = 1; j < 10; j++)
                    check("vec_spacing_a", 32'(pa_cyc[j] - pa_cyc[j-1]), 32'd2);
            end
            check("vec_busy_a", {31'd0, busy_a}, 32'd0);
            check("vec_busy_b", {31'd0, busy_b}, 32'd0);
        end

        // stall after the third character
        n0 = na;
        nb0 = nb;
        model_push(8'h01);
        push(8'h01);
        k = 0;
        while (na - n0 < 3 && k < 100) begin tick(); k++; end
        check("stall_reach3", 32'(na - n0), 32'd3);
        tx_busy = 1'b1;
        hold_tx = tx_a;
        n1 = na;
        nb1 = nb;
        repeat (50) tick();
        check("stall_no_pulse_a", 32'(na - n1), 32'd0);
        check("stall_no_pulse_b", 32'(nb - nb1), 32'd0);
        check("stall_tx_stable", {24'd0, tx_a}, {24'd0, hold_tx});
        pa_cyc.delete();
        tx_busy = 1'b0;
        r = cyc;
        k = 0;
        while (na == n1 && k < 10) begin tick(); k++; end
        check("stall_resume", 32'(pa_cyc.size() > 0 && (pa_cyc[0] - r) <= 1), 32'd1);
        wait_idle("stall", 200);
        check("stall_total_a", 32'(na - n0), 32'd10);
        check("stall_total_b", 32'(nb - nb0), 32'd8);

        // push while the FSM pops from a one-entry FIFO
        model_push(8'h5A);
        model_push(8'hA6);
        push(8'h5A);
        push(8'hA6);
        check("pushpop_cnt_a", {29'd0, cnt_a}, 32'd1);
        check("pushpop_cnt_b", {29'd0, cnt_b}, 32'd1);
        wait_idle("pushpop", 300);
        check("pushpop_ovf_a", {31'd0, ovf_a}, 32'd0);

        // overflow: shift register plus FIFO_DEPTH entries, sixth byte dropped
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rb = 8'h10 + 8'(i);
            if (i < 5) model_push(rb);
            push(rb);
        end
        check("ovf_cnt_a", {29'd0, cnt_a}, 32'd4);
        check("ovf_ready_a", {31'd0, ready_a}, 32'd0);
        check("ovf_flag_a", {31'd0, ovf_a}, 32'd1);
        check("ovf_cnt_b", {29'd0, cnt_b}, 32'd4);
        check("ovf_flag_b", {31'd0, ovf_b}, 32'd1);
        n0 = na;
        nb0 = nb;
        tx_busy = 1'b0;
        wait_idle("ovf", 400);
        check("ovf_total_a", 32'(na - n0), 32'd50);
        check("ovf_total_b", 32'(nb - nb0), 32'd40);
        check("ovf_sticky_a", {31'd0, ovf_a}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("ovf_cleared_a", {31'd0, ovf_a}, 32'd0);
        check("ovf_cleared_b", {31'd0, ovf_b}, 32'd0);
        tick();

        // reset mid-byte with two bytes queued
        n0 = na;
        model_push(8'h81);
        model_push(8'h42);
        model_push(8'h24);
        push(8'h81);
        push(8'h42);
        push(8'h24);
        k = 0;
        while (na - n0 < 5 && k < 100) begin tick(); k++; end
        check("midrst_reach5", 32'(na - n0), 32'd5);
        check("midrst_queued", {29'd0, cnt_a}, 32'd2);
        rst = 1'b1;
        tick();
        qa.delete();
        qb.delete();
        rst = 1'b0;
        check("midrst_tx_a", {24'd0, tx_a}, 32'h00);
        check("midrst_new_a", {31'd0, new_tx_a}, 32'd0);
        check("midrst_ready_a", {31'd0, ready_a}, 32'd1);
        check("midrst_busy_a", {31'd0, busy_a}, 32'd0);
        check("midrst_cnt_a", {29'd0, cnt_a}, 32'd0);
        check("midrst_busy_b", {31'd0, busy_b}, 32'd0);
        n1 = na;
        nb1 = nb;
        repeat (30) tick();
        check("midrst_silent_a", 32'(na - n1), 32'd0);
        check("midrst_silent_b", 32'(nb - nb1), 32'd0);

        // randomized traffic and back-pressure against the reference queues
        for (int t = 0; t < 1500; t++) begin
            tx_busy = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0 &&
                (qa.size() + 9) / 10 < DEPTH && (qb.size() + 7) / 8 < DEPTH) begin
                rb = 8'($urandom_range(0, 255));
                check("rnd_ready_a", {31'd0, ready_a}, 32'd1);
                check("rnd_ready_b", {31'd0, ready_b}, 32'd1);
                model_push(rb);
                byte_in  = rb;
                new_byte = 1'b1;
            end
            tick();
            new_byte = 1'b0;
        end
        tx_busy = 1'b0;
        wait_idle("rnd", 400);
        check("rnd_ovf_a", {31'd0, ovf_a}, 32'd0);
        check("rnd_ovf_b", {31'd0, ovf_b}, 32'd0);
        check("rnd_cnt_a", {29'd0, cnt_a}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
